nk_board_engine: RTL and testbench

- Parametrised successor to the fixed 3x3 tic-tac-toe game core: N x N board, K-in-a-row win, two players (X, O), alternating turns.
- Accepts moves from the button controller and checks the win incrementally around the placed cell, one neighbour cell per clock.
- Exposes a random-access cell read port so the colour controller can render the board from the VGA counters.
- Sits on the 25 MHz pixel clock domain.

---
 rtl/nk_board_engine.sv | 250 +++++++++++++++++++++++++
 tb/tb_nk_board_engine.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nk_board_engine.sv
// ---------------------------------------------------------------------------
// nk_board_engine
//   N x N board with a K-in-a-row win rule for two alternating players (X, O).
//   A move is accepted in IDLE when it lands on an empty in-range cell. The
//   win check then walks outwards from the placed stone, one neighbour cell
//   per clock, over the rays E, W, S, N, SE, NW, SW, NE. Opposite rays share
//   one running count that starts at 1 for the placed stone.
//   A combinational read port lets the renderer fetch any cell.
//
// Ports
//   clk        pixel-domain clock
//   rst        asynchronous, active-low reset
//   new_game   synchronous clear, same effect as rst, highest priority
//   move_valid move request (pulse or level)
//   move_row   move target row
//   move_col   move target column
//   rd_row     render read row
//   rd_col     render read column
//   rd_cell    cell at (rd_row, rd_col): 00 empty, 01 X, 10 O; 00 if out of range
//   turn       player to move, 0 = X, 1 = O
//   busy       win check in progress
//   move_ack   one-cycle pulse, move accepted
//   move_err   one-cycle pulse, move rejected
//   game_over  game finished
//   winner     00 none, 01 X, 10 O
//   draw       board full without a winner
//   moves_made number of stones placed
// ---------------------------------------------------------------------------
module nk_board_engine #(
  parameter int N  = 3,
  parameter int K  = 3,
  parameter int RW = $clog2(N),
  parameter int MW = $clog2(N*N+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          new_game,
  input  logic          move_valid,
  input  logic [RW-1:0] move_row,
  input  logic [RW-1:0] move_col,
  input  logic [RW-1:0] rd_row,
  input  logic [RW-1:0] rd_col,
  output logic [1:0]    rd_cell,
  output logic          turn,
  output logic          busy,
  output logic          move_ack,
  output logic          move_err,
  output logic          game_over,
  output logic [1:0]    winner,
  output logic          draw,
  output logic [MW-1:0] moves_made
);

  localparam int CW = $clog2(K+1);
  localparam int IW = $clog2(N*N);

  localparam logic        [RW:0]   LAST_U = (RW+1)'(N-1);
  localparam logic signed [RW:0]   LAST_S = (RW+1)'(N-1);
  localparam logic signed [RW:0]   D_P1   = (RW+1)'(1);
  localparam logic signed [RW:0]   D_M1   = '1;
  localparam logic signed [RW:0]   D_0    = '0;
  localparam logic        [CW-1:0] K_C    = CW'(K);
  localparam logic        [CW-1:0] KM1_C  = CW'(K-1);
  localparam logic        [CW-1:0] ONE_C  = CW'(1);
  localparam logic        [MW-1:0] CELLS  = MW'(N*N);

  typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

  state_t state_q;

  logic [1:0] board [N*N];

  // Control of the ray scan
  logic [2:0]    dir_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] steps_q;

  // Scan datapath: origin, current position and mover symbol (loaded on accept)
  logic signed [RW:0] org_r_q, org_c_q;
  logic signed [RW:0] cur_r_q, cur_c_q;
  logic [1:0]         sym_q;

  function automatic logic [IW-1:0] cell_idx(input logic [RW-1:0] r,
                                             input logic [RW-1:0] c);
    return IW'(int'(r) * N + int'(c));
  endfunction

  // ---- Read port and move validation ----
  logic          rd_in, mv_in, mv_ok, accept;
  logic [IW-1:0] rd_idx, mv_idx;
  logic [1:0]    mover_sym;

  always_comb begin
    rd_in   = ({1'b0, rd_row} <= LAST_U) && ({1'b0, rd_col} <= LAST_U);
    rd_idx  = rd_in ? cell_idx(rd_row, rd_col) : '0;
    rd_cell = rd_in ? board[rd_idx] : 2'b00;

    mv_in   = ({1'b0, move_row} <= LAST_U) && ({1'b0, move_col} <= LAST_U);
    mv_idx  = mv_in ? cell_idx(move_row, move_col) : '0;
    mv_ok   = mv_in && (board[mv_idx] == 2'b00);
    accept  = (state_q == IDLE) && move_valid && mv_ok;

    mover_sym = turn ? 2'b10 : 2'b01;
  end

  // ---- Next cell along the current ray ----
  logic signed [RW:0] dr, dc, nxt_r, nxt_c;
  logic               nxt_in, nxt_match, ray_continue;
  logic [IW-1:0]      nxt_idx;
  logic [CW-1:0]      count_inc, steps_inc;

  always_comb begin
    dr = D_0;
    dc = D_0;
    case (dir_q)
      3'd0: begin dr = D_0;  dc = D_P1; end  // E
      3'd1: begin dr = D_0;  dc = D_M1; end  // W
      3'd2: begin dr = D_P1; dc = D_0;  end  // S
      3'd3: begin dr = D_M1; dc = D_0;  end  // N
      3'd4: begin dr = D_P1; dc = D_P1; end  // SE
      3'd5: begin dr = D_M1; dc = D_M1; end  // NW
      3'd6: begin dr = D_P1; dc = D_M1; end  // SW
      default: begin dr = D_M1; dc = D_P1; end  // NE
    endcase

    // The current position is always on the board, so one step leaves it by
    // at most one. When N is a power of two, row/col N wraps to a negative
    // value in RW+1 bits, which the sign test below still flags out of range.
    nxt_r     = cur_r_q + dr;
    nxt_c     = cur_c_q + dc;
    nxt_in    = !nxt_r[RW] && !nxt_c[RW] && (nxt_r <= LAST_S) && (nxt_c <= LAST_S);
    nxt_idx   = nxt_in ? cell_idx(nxt_r[RW-1:0], nxt_c[RW-1:0]) : '0;
    nxt_match = nxt_in && (board[nxt_idx] == sym_q);

    count_inc = count_q + ONE_C;
    steps_inc = steps_q + ONE_C;
    // Keep walking only on a match that neither wins nor uses the last step
    ray_continue = nxt_match && (count_inc != K_C) && (steps_inc != KM1_C);
  end

  // ---- Scan datapath registers ----
  always_ff @(posedge clk) begin
    if (accept) begin
      org_r_q <= $signed({1'b0, move_row});
      org_c_q <= $signed({1'b0, move_col});
      cur_r_q <= $signed({1'b0, move_row});
      cur_c_q <= $signed({1'b0, move_col});
      sym_q   <= mover_sym;
    end else if (state_q == CHECK) begin
      if (ray_continue) begin
        cur_r_q <= nxt_r;
        cur_c_q <= nxt_c;
      end else begin
        cur_r_q <= org_r_q;
        cur_c_q <= org_c_q;
      end
    end
  end

  // ---- Game FSM, board storage and status outputs ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      for (int i = 0; i < N*N; i++) board[i] <= 2'b00;
      dir_q      <= '0;
      count_q    <= '0;
      steps_q    <= '0;
      turn       <= 1'b0;
      busy       <= 1'b0;
      move_ack   <= 1'b0;
      move_err   <= 1'b0;
      game_over  <= 1'b0;
      winner     <= 2'b00;
      draw       <= 1'b0;
      moves_made <= '0;
    end else if (new_game) begin
      state_q    <= IDLE;
      for (int i = 0; i < N*N; i++) board[i] <= 2'b00;
      dir_q      <= '0;
      count_q    <= '0;
      steps_q    <= '0;
      turn       <= 1'b0;
      busy       <= 1'b0;
      move_ack   <= 1'b0;
      move_err   <= 1'b0;
      game_over  <= 1'b0;
      winner     <= 2'b00;
      draw       <= 1'b0;
      moves_made <= '0;
    end else begin
      move_ack <= 1'b0;
      move_err <= 1'b0;
      case (state_q)
        IDLE: begin
          if (move_valid) begin
            if (mv_ok) begin
              board[mv_idx] <= mover_sym;
              moves_made    <= moves_made + MW'(1);
              move_ack      <= 1'b1;
              busy          <= 1'b1;
              dir_q         <= '0;
              count_q       <= ONE_C;
              steps_q       <= '0;
              state_q       <= CHECK;
            end else begin
              move_err <= 1'b1;
            end
          end
        end

        CHECK: begin
          if (move_valid) move_err <= 1'b1;
          if (nxt_match && (count_inc == K_C)) begin
            state_q   <= DONE;
            game_over <= 1'b1;
            winner    <= sym_q;
            busy      <= 1'b0;
          end else if (ray_continue) begin
            count_q <= count_inc;
            steps_q <= steps_inc;
          end else begin
            // Ray ends here; an odd direction closes its pair, so the next
            // pair restarts counting from the placed stone.
            steps_q <= '0;
            if (dir_q[0])       count_q <= ONE_C;
            else if (nxt_match) count_q <= count_inc;
            if (dir_q == 3'd7) begin
              busy <= 1'b0;
              if (moves_made == CELLS) begin
                state_q   <= DONE;
                game_over <= 1'b1;
                draw      <= 1'b1;
              end else begin
                state_q <= IDLE;
                turn    <= ~turn;
              end
            end else begin
              dir_q <= dir_q + 3'd1;
            end
          end
        end

        default: begin
          if (move_valid) move_err <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nk_board_engine.sv
// ---------------------------------------------------------------------------
// tb_nk_board_engine
//   Drives a 3x3/K=3 and a 5x5/K=4 instance (one selected at a time) and
//   compares every move response, check duration, status output and board
//   readback against a game model that scans rays over a plain int array.
// ---------------------------------------------------------------------------
module tb_nk_board_engine;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic       rst, new_game, move_valid, sel;
  logic [2:0] mrow, mcol, rrow, rcol;

  logic [1:0] rd3, win3, rd5, win5;
  logic       turn3, busy3, ack3, err3, over3, draw3;
  logic       turn5, busy5, ack5, err5, over5, draw5;
  logic [3:0] mm3;
  logic [4:0] mm5;
  logic       mv3, mv5;

  assign mv3 = move_valid & ~sel;
  assign mv5 = move_valid & sel;

  nk_board_engine #(.N(3), .K(3)) u3 (
    .clk(clk), .rst(rst), .new_game(new_game), .move_valid(mv3),
    .move_row(mrow[1:0]), .move_col(mcol[1:0]),
    .rd_row(rrow[1:0]), .rd_col(rcol[1:0]), .rd_cell(rd3),
    .turn(turn3), .busy(busy3), .move_ack(ack3), .move_err(err3),
    .game_over(over3), .winner(win3), .draw(draw3), .moves_made(mm3)
  );

  nk_board_engine #(.N(5), .K(4)) u5 (
    .clk(clk), .rst(rst), .new_game(new_game), .move_valid(mv5),
    .move_row(mrow), .move_col(mcol),
    .rd_row(rrow), .rd_col(rcol), .rd_cell(rd5),
    .turn(turn5), .busy(busy5), .move_ack(ack5), .move_err(err5),
    .game_over(over5), .winner(win5), .draw(draw5), .moves_made(mm5)
  );

  logic [1:0] cur_rd, cur_win;
  logic       cur_turn, cur_busy, cur_ack, cur_err, cur_over, cur_draw;
  logic [4:0] cur_mm;

  always_comb begin
    if (sel) begin
      cur_rd = rd5; cur_win = win5; cur_turn = turn5; cur_busy = busy5;
      cur_ack = ack5; cur_err = err5; cur_over = over5; cur_draw = draw5;
      cur_mm = mm5;
    end else begin
      cur_rd = rd3; cur_win = win3; cur_turn = turn3; cur_busy = busy3;
      cur_ack = ack3; cur_err = err3; cur_over = over3; cur_draw = draw3;
      cur_mm = {1'b0, mm3};
    end
  end

  int checks = 0;
  int failures = 0;

  // Game model
  int mb [5][5];
  int m_turn, m_moves, m_over, m_winner, m_draw;
  int n_cur, k_cur;

  task automatic model_clear();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) mb[r][c] = 0;
    m_turn = 0; m_moves = 0; m_over = 0; m_winner = 0; m_draw = 0;
  endtask

  task automatic use_dut(input bit s);
    sel = s;
    n_cur = s ? 5 : 3;
    k_cur = s ? 4 : 3;
  endtask

  // Walks the eight rays from the placed stone; returns 1 on a win and the
  // number of cells examined (one per clock) in lat.
  function automatic int ray_check(input int r, input int c, output int lat);
    int dr [8] = '{0, 0, 1, -1, 1, -1, 1, -1};
    int dc [8] = '{1, -1, 0, 0, 1, -1, -1, 1};
    int sym, cnt, rr, cc;
    sym = mb[r][c];
    lat = 0;
    cnt = 1;
    for (int d = 0; d < 8; d++) begin
      if (d % 2 == 0) cnt = 1;
      for (int j = 1; j < k_cur; j++) begin
        rr = r + dr[d] * j;
        cc = c + dc[d] * j;
        lat++;
        if (rr < 0 || cc < 0 || rr >= n_cur || cc >= n_cur) break;
        if (mb[rr][cc] != sym) break;
        cnt++;
        if (cnt == k_cur) return 1;
      end
    end
    return 0;
  endfunction

  task automatic pulse_new_game();
    @(negedge clk); new_game = 1'b1;
    @(posedge clk); #1; new_game = 1'b0;
    model_clear();
  endtask

  task automatic check_board(input string tag);
    int exp_v;
    for (int r = 0; r <= n_cur; r++)
      for (int c = 0; c <= n_cur; c++) begin
        rrow = 3'(r); rcol = 3'(c); #1;
        exp_v = (r < n_cur && c < n_cur) ? mb[r][c] : 0;
        checks++;
        if (cur_rd !== 2'(exp_v)) begin
          failures++;
          $display("FAIL board_%s (%0d,%0d): got %0d required %0d", tag, r, c, cur_rd, exp_v);
        end
      end
  endtask

  // One move attempt: response pulse, check duration and final status against
  // the model. With poke set, a second request is issued while busy.
  task automatic apply_move(input int r, input int c, input bit poke, output int lat_seen);
    int ok, lat, win, cyc;
    ok = (r < n_cur && c < n_cur && m_over == 0) ? (mb[r][c] == 0) : 0;
    lat = 0;
    @(negedge clk); mrow = 3'(r); mcol = 3'(c); move_valid = 1'b1;
    @(posedge clk); #1; move_valid = 1'b0;
    checks++;
    if (cur_ack !== ok[0] || cur_err !== !ok[0]) begin
      failures++;
      $display("FAIL move_resp (%0d,%0d): ack=%0b err=%0b required ack=%0b err=%0b",
               r, c, cur_ack, cur_err, ok[0], !ok[0]);
    end
    lat_seen = 0;
    if (ok != 0) begin
      mb[r][c] = m_turn + 1;
      m_moves++;
      win = ray_check(r, c, lat);
      cyc = 0;
      if (poke) begin
        mrow = 3'($urandom_range(0, n_cur - 1));
        mcol = 3'($urandom_range(0, n_cur - 1));
        move_valid = 1'b1;
        @(posedge clk); #1; move_valid = 1'b0;
        cyc = 1;
        checks++;
        if (cur_err !== 1'b1 || cur_ack !== 1'b0) begin
          failures++;
          $display("FAIL busy_reject: err=%0b ack=%0b required err=1 ack=0", cur_err, cur_ack);
        end
      end
      while (cur_busy === 1'b1 && cyc < 200) begin
        @(posedge clk); #1; cyc++;
      end
      lat_seen = cyc;
      checks++;
      if (cyc != lat) begin
        failures++;
        $display("FAIL check_cycles (%0d,%0d): got %0d required %0d", r, c, cyc, lat);
      end
      if (win != 0) begin
        m_over = 1; m_winner = m_turn + 1;
      end else if (m_moves == n_cur * n_cur) begin
        m_over = 1; m_draw = 1;
      end else begin
        m_turn = m_turn ^ 1;
      end
    end else begin
      @(posedge clk); #1;
      checks++;
      if (cur_err !== 1'b0) begin
        failures++;
        $display("FAIL err_pulse_width: err=%0b required 0", cur_err);
      end
    end
    checks++;
    if (cur_turn !== m_turn[0] || cur_busy !== 1'b0 || cur_ack !== 1'b0 ||
        cur_over !== m_over[0] || cur_win !== m_winner[1:0] || cur_draw !== m_draw[0]) begin
      failures++;
      $display("FAIL status (%0d,%0d): turn=%0b busy=%0b ack=%0b over=%0b win=%0d draw=%0b required turn=%0b busy=0 ack=0 over=%0b win=%0d draw=%0b",
               r, c, cur_turn, cur_busy, cur_ack, cur_over, cur_win, cur_draw,
               m_turn[0], m_over[0], m_winner, m_draw[0]);
    end
    checks++;
    if (cur_mm !== 5'(m_moves)) begin
      failures++;
      $display("FAIL moves_made: got %0d required %0d", cur_mm, m_moves);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; new_game = 1'b0; move_valid = 1'b0;
    mrow = '0; mcol = '0; rrow = '0; rcol = '0;
    use_dut(1'b0);
    model_clear();
    @(posedge clk); #1;
    checks++;
    if ({turn3, busy3, ack3, err3, over3, win3, draw3, mm3} !== 11'd0) begin
      failures++;
      $display("FAIL reset_dut3: outputs=%b required all zero",
               {turn3, busy3, ack3, err3, over3, win3, draw3, mm3});
    end
    checks++;
    if ({turn5, busy5, ack5, err5, over5, win5, draw5, mm5} !== 12'd0) begin
      failures++;
      $display("FAIL reset_dut5: outputs=%b required all zero",
               {turn5, busy5, ack5, err5, over5, win5, draw5, mm5});
    end
    @(negedge clk); rst = 1'b1;
    check_board("reset");
  endtask

  task automatic test_first_win();
    int lat;
    use_dut(1'b0);
    pulse_new_game();
    apply_move(0, 0, 1'b0, lat);
    apply_move(1, 0, 1'b0, lat);
    apply_move(0, 1, 1'b0, lat);
    apply_move(1, 1, 1'b0, lat);
    apply_move(0, 2, 1'b0, lat);
    checks++;
    if (lat != 3 || cur_win !== 2'b01 || cur_over !== 1'b1) begin
      failures++;
      $display("FAIL x_row_win: lat=%0d win=%0d over=%0b required lat=3 win=1 over=1", lat, cur_win, cur_over);
    end
    apply_move(2, 2, 1'b0, lat);
    check_board("first_win");
  endtask

  task automatic test_rejects();
    int lat;
    use_dut(1'b0);
    pulse_new_game();
    apply_move(1, 1, 1'b0, lat);
    apply_move(1, 1, 1'b0, lat);
    apply_move(3, 0, 1'b0, lat);
    apply_move(0, 3, 1'b0, lat);
    checks++;
    if (cur_turn !== 1'b1 || cur_mm !== 5'd1) begin
      failures++;
      $display("FAIL reject_state: turn=%0b moves=%0d required turn=1 moves=1", cur_turn, cur_mm);
    end
    check_board("rejects");
  endtask

  task automatic test_back_to_back();
    int lat;
    use_dut(1'b0);
    pulse_new_game();
    apply_move(0, 0, 1'b1, lat);
    checks++;
    if (cur_turn !== 1'b1 || cur_mm !== 5'd1) begin
      failures++;
      $display("FAIL back_to_back: turn=%0b moves=%0d required turn=1 moves=1", cur_turn, cur_mm);
    end
    check_board("back_to_back");
  endtask

  task automatic test_draw();
    int lat;
    int seq [9][2] = '{'{0,0}, '{0,1}, '{0,2}, '{1,1}, '{1,0}, '{1,2}, '{2,1}, '{2,0}, '{2,2}};
    use_dut(1'b0);
    pulse_new_game();
    for (int i = 0; i < 9; i++) apply_move(seq[i][0], seq[i][1], 1'b0, lat);
    checks++;
    if (cur_draw !== 1'b1 || cur_win !== 2'b00 || cur_mm !== 5'd9 || cur_over !== 1'b1) begin
      failures++;
      $display("FAIL draw: draw=%0b win=%0d moves=%0d over=%0b required 1 0 9 1", cur_draw, cur_win, cur_mm, cur_over);
    end
    check_board("draw");
  endtask

  task automatic test_diag_5x5();
    int lat;
    int seq [7][2] = '{'{4,0}, '{0,3}, '{4,1}, '{2,1}, '{4,2}, '{3,0}, '{2,4}};
    use_dut(1'b1);
    pulse_new_game();
    for (int i = 0; i < 7; i++) apply_move(seq[i][0], seq[i][1], 1'b0, lat);
    checks++;
    if (cur_over !== 1'b0 || cur_win !== 2'b00) begin
      failures++;
      $display("FAIL no_false_win: over=%0b win=%0d required 0 0", cur_over, cur_win);
    end
    apply_move(1, 2, 1'b0, lat);
    checks++;
    if (cur_over !== 1'b1 || cur_win !== 2'b10) begin
      failures++;
      $display("FAIL o_diag_win: over=%0b win=%0d required 1 2", cur_over, cur_win);
    end
    check_board("diag");
  endtask

  task automatic test_abort_in_check();
    int lat;
    // Asynchronous reset while the check runs
    use_dut(1'b0);
    pulse_new_game();
    @(negedge clk); mrow = 3'd0; mcol = 3'd0; move_valid = 1'b1;
    @(posedge clk); #1; move_valid = 1'b0;
    #5 rst = 1'b0;
    #1;
    checks++;
    if ({cur_turn, cur_busy, cur_ack, cur_err, cur_over, cur_win, cur_draw, cur_mm} !== 12'd0) begin
      failures++;
      $display("FAIL async_reset_abort: outputs=%b required all zero",
               {cur_turn, cur_busy, cur_ack, cur_err, cur_over, cur_win, cur_draw, cur_mm});
    end
    model_clear();
    check_board("async_reset");
    @(negedge clk); rst = 1'b1;
    apply_move(2, 2, 1'b0, lat);
    rrow = 3'd2; rcol = 3'd2; #1;
    checks++;
    if (cur_rd !== 2'b01) begin
      failures++;
      $display("FAIL post_reset_mover: cell=%0d required 1", cur_rd);
    end
    // Synchronous new_game while the check runs
    @(negedge clk); mrow = 3'd1; mcol = 3'd1; move_valid = 1'b1;
    @(posedge clk); #1; move_valid = 1'b0;
    @(negedge clk); new_game = 1'b1;
    @(posedge clk); #1; new_game = 1'b0;
    checks++;
    if ({cur_turn, cur_busy, cur_ack, cur_err, cur_over, cur_win, cur_draw, cur_mm} !== 12'd0) begin
      failures++;
      $display("FAIL new_game_abort: outputs=%b required all zero",
               {cur_turn, cur_busy, cur_ack, cur_err, cur_over, cur_win, cur_draw, cur_mm});
    end
    model_clear();
    check_board("new_game");
    apply_move(0, 1, 1'b0, lat);
    rrow = 3'd0; rcol = 3'd1; #1;
    checks++;
    if (cur_rd !== 2'b01) begin
      failures++;
      $display("FAIL post_new_game_mover: cell=%0d required 1", cur_rd);
    end
  endtask

  task automatic test_random_games(input bit s, input int games);
    int lat, r, c;
    use_dut(s);
    for (int g = 0; g < games; g++) begin
      pulse_new_game();
      for (int a = 0; a < 60 && m_over == 0; a++) begin
        r = $urandom_range(0, n_cur);
        c = $urandom_range(0, n_cur);
        apply_move(r, c, ($urandom_range(0, 3) == 0), lat);
      end
      apply_move($urandom_range(0, n_cur - 1), $urandom_range(0, n_cur - 1), 1'b0, lat);
      check_board("random");
    end
  endtask

  initial begin
    test_reset();
    test_first_win();
    test_rejects();
    test_back_to_back();
    test_draw();
    test_diag_5x5();
    test_abort_in_check();
    test_random_games(1'b0, 8);
    test_random_games(1'b1, 4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
